// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the Ethernet TX arbiter.
// Holds the arbiter state encoding, the requester index constants and
// small index helpers used by eth_tx_arb and eth_rr_pick.
package eth_pkg;

  localparam int NUM_TX_REQ = 3;

  localparam int REQ_ARP  = 0;
  localparam int REQ_ICMP = 1;
  localparam int REQ_UDP  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XMIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  // Index that follows idx in round-robin order, wrapping after the last requester.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'(NUM_TX_REQ - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

  // Requester index of a one-hot selection vector (0 when empty).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_TX_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'(REQ_ARP);
    if (oh[REQ_ICMP]) idx = 2'(REQ_ICMP);
    if (oh[REQ_UDP])  idx = 2'(REQ_UDP);
    return idx;
  endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// eth_rr_pick: combinational round-robin selector.
// Scans the pending vector starting at i_ptr and wrapping around; the first
// pending requester found is returned one-hot on o_pick with o_valid high.
module eth_rr_pick
  import eth_pkg::*;
(
  input  logic [NUM_TX_REQ-1:0] i_pending,
  input  logic [1:0]            i_ptr,
  output logic [NUM_TX_REQ-1:0] o_pick,
  output logic                  o_valid
);

  logic [2:0] w_idx;

  // Walk the requesters in rotated order and keep the first pending one.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_TX_REQ; k++) begin
      w_idx = {1'b0, i_ptr} + 3'(k);
      if (w_idx >= 3'(NUM_TX_REQ)) begin
        w_idx = w_idx - 3'(NUM_TX_REQ);
      end
      if (!o_valid && i_pending[w_idx[1:0]]) begin
        o_pick[w_idx[1:0]] = 1'b1;
        o_valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: round-robin arbiter that shares one GMII TX path between the
// ARP, ICMP and UDP frame sources.
//
// Handshake: a source raises req_start for one clock to ask for the bus; the
// request is held in a pending bit until the arbiter answers with a one-clock
// grant pulse, which the source uses as its start strobe. The owner then
// drives its GMII lanes and signals the end of the frame with a one-clock
// req_done pulse. Only the owner's lanes and req_done are ever looked at.
//
// Optional feature: define ETH_TX_ARB_WDOG_EN to build a per-frame watchdog
// that aborts a frame lasting MAX_FRAME_CYCLES clocks; without it abort is 0.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES       = 12,
  parameter int unsigned MAX_FRAME_CYCLES = 3100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_TX_REQ-1:0]   req_start,
  input  logic [NUM_TX_REQ-1:0]   req_done,
  input  logic [NUM_TX_REQ-1:0]   req_gmii_tx_en,
  input  logic [8*NUM_TX_REQ-1:0] req_gmii_txd,
  output logic [NUM_TX_REQ-1:0]   grant,
  output logic                    gmii_tx_en,
  output logic [7:0]              gmii_txd,
  output logic                    busy,
  output logic                    abort,
  output arb_state_t              dbg_state
);

  // Last GAP count value; an IFG of 0 still spends one clock in GAP.
  localparam logic [15:0] GAP_LAST = (IFG_CYCLES == 0) ? 16'd0 : 16'(IFG_CYCLES - 1);

  arb_state_t            r_state;
  logic [NUM_TX_REQ-1:0] r_pending;
  logic [1:0]            r_ptr;
  logic [1:0]            r_owner;
  logic                  r_done_seen;
  logic [15:0]           r_gap_cnt;
  logic [NUM_TX_REQ-1:0] r_grant;
  logic                  r_tx_en;
  logic [7:0]            r_txd;

  logic [NUM_TX_REQ-1:0] w_pick;
  logic                  w_valid;
  logic [NUM_TX_REQ-1:0] w_clr;
  logic                  w_own_en;
  logic [7:0]            w_own_txd;
  logic                  w_own_done;

`ifdef ETH_TX_ARB_WDOG_EN
  localparam logic [15:0] WDOG_LAST = (MAX_FRAME_CYCLES == 0) ? 16'd0 : 16'(MAX_FRAME_CYCLES - 1);
  logic [15:0] r_wdog;
  logic        r_abort;
`endif

  eth_rr_pick u_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_pick    (w_pick),
    .o_valid   (w_valid)
  );

  // Pending bit of the requester being granted is cleared as the grant registers.
  always_comb begin
    w_clr = '0;
    if (r_state == ST_IDLE && w_valid) begin
      w_clr = w_pick;
    end
  end

  // Route the current owner's lanes and done strobe; all other sources are ignored.
  always_comb begin
    w_own_en   = 1'b0;
    w_own_txd  = 8'h00;
    w_own_done = 1'b0;
    case (r_owner)
      2'(REQ_ARP): begin
        w_own_en   = req_gmii_tx_en[REQ_ARP];
        w_own_txd  = req_gmii_txd[8*REQ_ARP +: 8];
        w_own_done = req_done[REQ_ARP];
      end
      2'(REQ_ICMP): begin
        w_own_en   = req_gmii_tx_en[REQ_ICMP];
        w_own_txd  = req_gmii_txd[8*REQ_ICMP +: 8];
        w_own_done = req_done[REQ_ICMP];
      end
      2'(REQ_UDP): begin
        w_own_en   = req_gmii_tx_en[REQ_UDP];
        w_own_txd  = req_gmii_txd[8*REQ_UDP +: 8];
        w_own_done = req_done[REQ_UDP];
      end
      default: ;
    endcase
  end

  // Arbiter FSM with its registered grant, data path and abort outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_done_seen <= 1'b0;
      r_gap_cnt   <= '0;
      r_grant     <= '0;
      r_tx_en     <= 1'b0;
      r_txd       <= 8'h00;
`ifdef ETH_TX_ARB_WDOG_EN
      r_wdog      <= '0;
      r_abort     <= 1'b0;
`endif
    end else begin
      // A new request in the clearing cycle keeps the pending bit set.
      r_pending <= (r_pending & ~w_clr) | req_start;
      r_grant   <= '0;
      r_tx_en   <= 1'b0;
      r_txd     <= 8'h00;
`ifdef ETH_TX_ARB_WDOG_EN
      r_abort   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state     <= ST_GRANT;
            r_grant     <= w_pick;
            r_owner     <= onehot_to_idx(w_pick);
            r_ptr       <= rr_next(onehot_to_idx(w_pick));
            r_done_seen <= 1'b0;
          end
        end
        ST_GRANT: begin
          // A done strobe this early is remembered and honoured in XMIT.
          r_state     <= ST_XMIT;
          r_done_seen <= w_own_done;
          r_tx_en     <= w_own_en;
          r_txd       <= w_own_txd;
`ifdef ETH_TX_ARB_WDOG_EN
          r_wdog      <= '0;
`endif
        end
        ST_XMIT: begin
          r_tx_en <= w_own_en;
          r_txd   <= w_own_txd;
          if (r_done_seen || w_own_done) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= '0;
          end
`ifdef ETH_TX_ARB_WDOG_EN
          else if (r_wdog == WDOG_LAST) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= '0;
            r_abort   <= 1'b1;
            r_tx_en   <= 1'b0;
            r_txd     <= 8'h00;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
`endif
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign gmii_tx_en = r_tx_en;
  assign gmii_txd   = r_txd;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;
`ifdef ETH_TX_ARB_WDOG_EN
  assign abort      = r_abort;
`else
  assign abort      = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: self-checking bench for eth_tx_arb (IFG 12, watchdog limit 100
// when ETH_TX_ARB_WDOG_EN is defined). Output bytes are tracked through an
// expected queue tagged with the cycle they must appear in.
`timescale 1ns/1ps
module tb_eth_tx_arb;
  import eth_pkg::*;

  localparam int IFG  = 12;
  localparam int MAXF = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_start = '0;
  logic [2:0]  req_done = '0;
  logic [2:0]  req_gmii_tx_en = '0;
  logic [23:0] req_gmii_txd = '0;
  logic [2:0]  grant;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        busy;
  logic        abort;
  arb_state_t  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [39:0] exp_q[$];
  int          grant_log[$];
  int          exp_grant[$];
  int          abort_cnt = 0;

  eth_tx_arb #(.IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(MAXF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_start      (req_start),
    .req_done       (req_done),
    .req_gmii_tx_en (req_gmii_tx_en),
    .req_gmii_txd   (req_gmii_txd),
    .grant          (grant),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_txd       (gmii_txd),
    .busy           (busy),
    .abort          (abort),
    .dbg_state      (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  logic [39:0] mon_e;
  logic        prev_en = 1'b0;
  logic [2:0]  prev_grant = '0;
  bit          have_last = 1'b0;
  int          last_tx_cyc = 0;

  always @(negedge clk) begin
    if (gmii_tx_en) begin
      if (!prev_en && have_last)
        check_eq("ifg_min", 32'((cyc - last_tx_cyc - 1) >= IFG), 32'd1);
      check_eq("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("tx_data", 32'(gmii_txd), 32'(mon_e[7:0]));
        check_eq("tx_latency", 32'(cyc), mon_e[39:8]);
      end
      last_tx_cyc = cyc;
      have_last   = 1'b1;
    end else if (gmii_txd != 8'h00) begin
      check_eq("txd_idle_zero", 32'(gmii_txd), 32'd0);
    end
    prev_en = gmii_tx_en;
    if (grant != 3'b000) begin
      check_eq("grant_onehot", 32'($countones(grant)), 32'd1);
      check_eq("grant_one_cycle", 32'(prev_grant), 32'd0);
      grant_log.push_back(grant[0] ? 0 : (grant[1] ? 1 : 2));
    end
    prev_grant = grant;
    if (abort) abort_cnt++;
  end

  // driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_start = '0; req_done = '0; req_gmii_tx_en = '0; req_gmii_txd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [2:0] mask);
    @(negedge clk);
    req_start = mask;
    @(negedge clk);
    req_start = '0;
  endtask

  task automatic wait_grant(input int idx, output int gcyc, output bit ok);
    int n;
    logic [2:0] m;
    n = 0;
    m = 3'(1 << idx);
    do begin
      @(negedge clk);
      n++;
    end while (!grant[idx] && n < 300);
    ok   = grant[idx];
    gcyc = cyc;
    check_eq("grant_val", 32'(grant), 32'(m));
    check_eq("busy_in_grant", 32'(busy), 32'd1);
  endtask

  // Owner idx sends nbytes; extra is pulsed on req_start during the grant
  // cycle; noise >= 0 names a non-owner that babbles on its lanes meanwhile.
  task automatic send_frame(input int idx, input int nbytes, input logic [2:0] extra, input int noise);
    int  g;
    bit  ok;
    logic [7:0] b;
    wait_grant(idx, g, ok);
    if (!ok) return;
    req_start = extra;
    @(negedge clk);
    req_start = '0;
    check_eq("grant_dropped", 32'(grant), 32'd0);
    for (int k = 0; k < nbytes; k++) begin
      b = 8'($urandom_range(0, 255));
      req_gmii_tx_en[idx]     = 1'b1;
      req_gmii_txd[idx*8 +: 8] = b;
      exp_q.push_back({32'(cyc + 1), b});
      if (noise >= 0) begin
        req_gmii_tx_en[noise]      = 1'b1;
        req_gmii_txd[noise*8 +: 8] = 8'hAA;
        req_done[noise]            = (k == 2);
      end
      req_done[idx] = (k == nbytes - 1);
      @(negedge clk);
    end
    req_gmii_tx_en = '0;
    req_gmii_txd   = '0;
    req_done       = '0;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, g;
    bit ok;
    int base;

    // reset state
    apply_reset();
    @(negedge clk);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    check_eq("rst_txd", 32'(gmii_txd), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_abort", 32'(abort), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // single ICMP frame of 64 bytes, GAP of exactly IFG clocks
    pulse_start(3'b010);
    exp_grant.push_back(1);
    send_frame(1, 64, 3'b000, -1);
    check_eq("in_gap", 32'(dbg_state), 32'(ST_GAP));
    wait_idle(100, n);
    check_eq("gap_len", 32'(n), 32'(IFG));
    check_eq("frame1_drained", 32'(exp_q.size()), 32'd0);

    // all three at once after reset: ARP, ICMP, UDP
    apply_reset();
    pulse_start(3'b111);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    send_frame(0, 8, 3'b000, -1);
    send_frame(1, 8, 3'b000, -1);
    send_frame(2, 8, 3'b000, -1);
    wait_idle(100, n);
    check_eq("rr3_drained", 32'(exp_q.size()), 32'd0);

    // ICMP owns the bus while ARP babbles, requests and strobes done
    pulse_start(3'b010);
    exp_grant.push_back(1); exp_grant.push_back(0);
    send_frame(1, 16, 3'b001, 0);
    send_frame(0, 4, 3'b000, -1);
    wait_idle(100, n);
    check_eq("noise_drained", 32'(exp_q.size()), 32'd0);

    // ARP re-requests in its own grant cycle and is granted again
    pulse_start(3'b001);
    exp_grant.push_back(0); exp_grant.push_back(0);
    send_frame(0, 4, 3'b001, -1);
    send_frame(0, 4, 3'b000, -1);
    wait_idle(100, n);
    repeat (30) @(negedge clk);
    check_eq("no_third_grant", 32'(grant_log.size()), 32'(exp_grant.size()));

`ifdef ETH_TX_ARB_WDOG_EN
    // ICMP never finishes: watchdog aborts, UDP follows after GAP
    pulse_start(3'b110);
    exp_grant.push_back(1); exp_grant.push_back(2);
    wait_grant(1, g, ok);
    if (ok) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!abort && n < 300);
      check_eq("abort_cycle", 32'(cyc), 32'(g + MAXF + 1));
      check_eq("abort_tx_en", 32'(gmii_tx_en), 32'd0);
      check_eq("abort_state", 32'(dbg_state), 32'(ST_GAP));
      @(negedge clk);
      check_eq("abort_pulse", 32'(abort), 32'd0);
    end
    send_frame(2, 4, 3'b000, -1);
    wait_idle(100, n);
`endif

    // reset mid-frame with ICMP and UDP pending
    pulse_start(3'b001);
    exp_grant.push_back(0);
    wait_grant(0, g, ok);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      req_gmii_tx_en[0]  = 1'b1;
      req_gmii_txd[7:0]  = 8'(8'h10 + k);
      exp_q.push_back({32'(cyc + 1), 8'(8'h10 + k)});
      req_start = (k == 1) ? 3'b110 : 3'b000;
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    req_gmii_tx_en = '0; req_gmii_txd = '0; req_start = '0;
    #1;
    check_eq("mrst_tx_en", 32'(gmii_tx_en), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    check_eq("mrst_txd_edge", 32'(gmii_txd), 32'd0);
    check_eq("mrst_grant_edge", 32'(grant), 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    base = grant_log.size();
    repeat (40) @(negedge clk);
    check_eq("mrst_no_grant", 32'(grant_log.size()), 32'(base));
    check_eq("mrst_idle", 32'(busy), 32'd0);
    pulse_start(3'b100);
    exp_grant.push_back(2);
    send_frame(2, 4, 3'b000, -1);
    wait_idle(100, n);

    // final scoreboard
    repeat (3) @(negedge clk);
    check_eq("final_drained", 32'(exp_q.size()), 32'd0);
    check_eq("grant_count", 32'(grant_log.size()), 32'(exp_grant.size()));
    for (int i = 0; i < exp_grant.size() && i < grant_log.size(); i++)
      check_eq("grant_order", 32'(grant_log[i]), 32'(exp_grant[i]));
`ifdef ETH_TX_ARB_WDOG_EN
    check_eq("abort_count", 32'(abort_cnt), 32'd1);
`else
    check_eq("abort_count", 32'(abort_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
